// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and AXI constants for the instruction-fetch front end.
//   fetch_state_t  - fetch FSM state encoding
//   AXI_BURST_INCR - ARBURST encoding for incrementing bursts
//   AXI_RESP_OKAY  - RRESP encoding for a successful beat
package fetch_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOOKUP,
        S_CHECK,
        S_AR,
        S_RDATA,
        S_DRAIN,
        S_UNPACK,
        S_FAULT,
        S_HALT
    } fetch_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO with flush.
//   clk, reset (async, active-low)
//   flush            - empty the queue; beats push and pop
//   push, push_data  - write when not full (no push-through when full)
//   pop, pop_data    - head shown combinationally; pop when not empty
//   full, empty      - occupancy flags
module fetch_queue #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (!do_push && do_pop) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pipeline_fetch_burst.sv
// pipeline_fetch_burst: instruction-fetch front end.
//   redirect_valid/redirect_pc - flush and restart fetch at a new PC
//   cache_addr/cache_hit/cache_rdata - beat lookup (hit one cycle after addr)
//   cache_fill_*  - one cache write per good AXI read beat
//   m_axi_ar*/r*  - single outstanding INCR line refill
//   if_valid/if_ready/if_pc/if_instruction/if_fault - instruction queue head
module pipeline_fetch_burst
    import fetch_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH  = 64,
    parameter int unsigned          DATA_WIDTH  = 64,
    parameter int unsigned          INSTR_WIDTH = 32,
    parameter int unsigned          BURST_LEN   = 8,
    parameter int unsigned          FIFO_DEPTH  = 4,
    parameter int unsigned          ID_WIDTH    = 13,
    parameter logic [ID_WIDTH-1:0]  FETCH_ID    = '0,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic [ADDR_WIDTH-1:0]  cache_addr,
    input  logic                   cache_hit,
    input  logic [DATA_WIDTH-1:0]  cache_rdata,
    output logic                   cache_fill_valid,
    output logic [ADDR_WIDTH-1:0]  cache_fill_addr,
    output logic [DATA_WIDTH-1:0]  cache_fill_data,
    output logic                   cache_fill_last,
    output logic [ID_WIDTH-1:0]    m_axi_arid,
    output logic [ADDR_WIDTH-1:0]  m_axi_araddr,
    output logic [7:0]             m_axi_arlen,
    output logic [2:0]             m_axi_arsize,
    output logic [1:0]             m_axi_arburst,
    output logic                   m_axi_arvalid,
    input  logic                   m_axi_arready,
    input  logic [DATA_WIDTH-1:0]  m_axi_rdata,
    input  logic [1:0]             m_axi_rresp,
    input  logic                   m_axi_rlast,
    input  logic                   m_axi_rvalid,
    output logic                   m_axi_rready,
    output logic                   if_valid,
    input  logic                   if_ready,
    output logic [ADDR_WIDTH-1:0]  if_pc,
    output logic [INSTR_WIDTH-1:0] if_instruction,
    output logic                   if_fault
);

    localparam int unsigned IPB         = DATA_WIDTH / INSTR_WIDTH;
    localparam int unsigned BEAT_BYTES  = DATA_WIDTH / 8;
    localparam int unsigned INSTR_BYTES = INSTR_WIDTH / 8;
    localparam int unsigned BEAT_LSB    = $clog2(BEAT_BYTES);
    localparam int unsigned INSTR_LSB   = $clog2(INSTR_BYTES);
    localparam int unsigned SLOT_W      = (IPB > 1) ? $clog2(IPB) : 1;
    localparam int unsigned CNT_W       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [ADDR_WIDTH-1:0] BEAT_MASK = ADDR_WIDTH'(BEAT_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(BURST_LEN * BEAT_BYTES - 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
        logic                   fault;
    } fetch_entry_t;

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] beat_q, beat_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic                  err_q, err_d;
    logic                  ar_redir_q, ar_redir_d;

    logic [IPB-1:0][INSTR_WIDTH-1:0] beat_slots;
    logic [SLOT_W-1:0]     slot;
    logic                  last_slot;
    logic [INSTR_WIDTH-1:0] beat_instr;
    logic                  beat_ok;
    logic                  push;
    logic                  flush;
    logic                  q_full;
    logic                  q_empty;
    fetch_entry_t          push_entry;
    fetch_entry_t          head;

    assign beat_slots = beat_q;
    assign slot       = pc_q[INSTR_LSB +: SLOT_W];
    assign last_slot  = (IPB == 1) || (slot == SLOT_W'(IPB - 1));
    assign beat_instr = (IPB > 1) ? beat_slots[slot] : beat_slots[0];
    assign beat_ok    = (m_axi_rresp == AXI_RESP_OKAY);

    assign cache_addr    = (state_q == S_IDLE) ? '0 : (pc_q & ~BEAT_MASK);
    assign m_axi_arid    = FETCH_ID;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = 8'(BURST_LEN - 1);
    assign m_axi_arsize  = 3'(BEAT_LSB);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arvalid = (state_q == S_AR);
    assign m_axi_rready  = (state_q == S_RDATA) || (state_q == S_DRAIN);

    assign cache_fill_valid = m_axi_rready && m_axi_rvalid && beat_ok;
    assign cache_fill_addr  = cache_fill_valid ? (araddr_q + (ADDR_WIDTH'(beat_cnt_q) << BEAT_LSB)) : '0;
    assign cache_fill_data  = cache_fill_valid ? m_axi_rdata : '0;
    assign cache_fill_last  = cache_fill_valid && m_axi_rlast;

    assign if_valid       = !q_empty;
    assign if_pc          = q_empty ? '0 : head.pc;
    assign if_instruction = q_empty ? '0 : head.instr;
    assign if_fault       = !q_empty && head.fault;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            beat_q     <= '0;
            araddr_q   <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
            ar_redir_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            beat_q     <= beat_d;
            araddr_q   <= araddr_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
            ar_redir_q <= ar_redir_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        beat_d     = beat_q;
        araddr_d   = araddr_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        ar_redir_d = ar_redir_q;
        push       = 1'b0;
        flush      = 1'b0;
        push_entry = '0;

        unique case (state_q)
            S_IDLE:   state_d = S_LOOKUP;
            S_LOOKUP: state_d = S_CHECK;
            S_CHECK: begin
                if (cache_hit) begin
                    beat_d  = cache_rdata;
                    state_d = S_UNPACK;
                end else begin
                    araddr_d   = pc_q & ~LINE_MASK;
                    beat_cnt_d = '0;
                    err_d      = 1'b0;
                    ar_redir_d = 1'b0;
                    state_d    = S_AR;
                end
            end
            S_AR: begin
                if (m_axi_arready) state_d = ar_redir_q ? S_DRAIN : S_RDATA;
            end
            S_RDATA: begin
                if (m_axi_rvalid) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (!beat_ok) err_d = 1'b1;
                    if (m_axi_rlast) begin
                        beat_cnt_d = '0;
                        if (err_q || !beat_ok) begin
                            // A full queue defers the fault marker to S_FAULT.
                            push_entry = '{pc: pc_q, instr: '0, fault: 1'b1};
                            push       = !q_full;
                            state_d    = q_full ? S_FAULT : S_HALT;
                        end else begin
                            state_d = S_LOOKUP;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (m_axi_rvalid) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (m_axi_rlast) begin
                        beat_cnt_d = '0;
                        state_d    = S_LOOKUP;
                    end
                end
            end
            S_UNPACK: begin
                if (!q_full) begin
                    push_entry = '{pc: pc_q, instr: beat_instr, fault: 1'b0};
                    push       = 1'b1;
                    pc_d       = pc_q + ADDR_WIDTH'(INSTR_BYTES);
                    if (last_slot) state_d = S_LOOKUP;
                end
            end
            S_FAULT: begin
                push_entry = '{pc: pc_q, instr: '0, fault: 1'b1};
                push       = !q_full;
                if (!q_full) state_d = S_HALT;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase

        // Redirect overrides everything above except the AXI bookkeeping of
        // a burst in flight, which must still run to rlast.
        if (redirect_valid) begin
            flush  = 1'b1;
            push   = 1'b0;
            pc_d   = redirect_pc;
            beat_d = '0;
            unique case (state_q)
                S_AR: begin
                    ar_redir_d = 1'b1;
                    state_d    = m_axi_arready ? S_DRAIN : S_AR;
                end
                S_RDATA: state_d = (m_axi_rvalid && m_axi_rlast) ? S_LOOKUP : S_DRAIN;
                S_DRAIN: state_d = state_d;
                default: state_d = S_LOOKUP;
            endcase
        end
    end

    fetch_queue #(
        .WIDTH($bits(fetch_entry_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .push_data (push_entry),
        .pop       (if_valid && if_ready),
        .pop_data  (head),
        .full      (q_full),
        .empty     (q_empty)
    );

endmodule
